// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - RAM read port and output stream bundle for ram_stream_reader
interface ram_stream_reader_if #(
  parameter int BITWIDTH = 32,
  parameter int AW       = 11
);
  logic                ram_write_en;
  logic [AW-1:0]       ram_addr;
  logic [BITWIDTH-1:0] ram_wdata;
  logic [BITWIDTH-1:0] ram_rdata;
  logic                valid;
  logic [BITWIDTH-1:0] data;
  logic                ready;

  modport master (
    output ram_write_en, ram_addr, ram_wdata, valid, data,
    input  ram_rdata, ready
  );

  modport slave (
    input  ram_write_en, ram_addr, ram_wdata, valid, data,
    output ram_rdata, ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - sequential RAM reader with latency tracking, credit-gated return FIFO and valid/ready output
module ram_stream_reader #(
  parameter  int BITWIDTH   = 32,
  parameter  int DEPTH      = 2048,
  parameter  int LATENCY    = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  ram_stream_reader_if.master bus
);

  localparam int LW = AW + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state;
  logic [AW-1:0]       addr;
  logic [AW-1:0]       last_addr;
  logic [LW-1:0]       remaining;
  logic [LATENCY-1:0]  pipe;
  logic [BITWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       inflight_count;
  logic [CW-1:0]       credit_used;
  logic                issue;
  logic                push;
  logic                pop;
  logic                drain_done;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_count = inflight_count + CW'(pipe[i]);
    end
  end

  // Credit uses registered counts only; a pop frees its slot one cycle later.
  assign credit_used = inflight_count + fifo_count;
  assign issue       = (state == S_READ) && (remaining != '0) && (credit_used < CW'(FIFO_DEPTH));
  assign push        = pipe[LATENCY-1];
  assign pop         = bus.valid && bus.ready;
  assign drain_done  = (inflight_count == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  assign bus.valid        = (fifo_count != '0);
  assign bus.data         = fifo_mem[rd_ptr];
  assign bus.ram_addr     = issue ? addr : last_addr;
  assign bus.ram_write_en = 1'b0;
  assign bus.ram_wdata    = '0;
  assign busy             = (state == S_READ) || (state == S_DRAIN);
  assign done             = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      last_addr <= '0;
      remaining <= '0;
      pipe      <= '0;
    end else begin
      pipe <= LATENCY'({pipe, issue});
      if (issue) begin
        last_addr <= addr;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base;
            remaining <= len;
            state     <= (len == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            addr      <= addr_inc(addr);
            remaining <= remaining - LW'(1);
            if (remaining == LW'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.ram_rdata;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  // The credit rule makes this unreachable; firing means the credit logic is broken.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (fifo_count == CW'(FIFO_DEPTH))));
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader (LATENCY=1 and LATENCY=3 instances)
module tb_ram_stream_reader;
  localparam int BW    = 32;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_start, a_busy, a_done;
  logic [AW-1:0] a_base;
  logic [AW:0]   a_len;
  logic          b_start, b_busy, b_done;
  logic [AW-1:0] b_base;
  logic [AW:0]   b_len;

  ram_stream_reader_if #(.BITWIDTH(BW), .AW(AW)) bus_a ();
  ram_stream_reader_if #(.BITWIDTH(BW), .AW(AW)) bus_b ();

  ram_stream_reader #(.BITWIDTH(BW), .DEPTH(DEPTH), .LATENCY(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .base(a_base), .len(a_len),
    .busy(a_busy), .done(a_done), .bus(bus_a)
  );

  ram_stream_reader #(.BITWIDTH(BW), .DEPTH(DEPTH), .LATENCY(3), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .base(b_base), .len(b_len),
    .busy(b_busy), .done(b_done), .bus(bus_b)
  );

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return 32'hC000_0000 | {21'd0, a};
  endfunction

  // RAM models: LATENCY=1 and LATENCY=3 read pipes.
  always @(posedge clk) bus_a.ram_rdata <= word_of(bus_a.ram_addr);
  logic [31:0] rb_pipe [3];
  always @(posedge clk) begin
    rb_pipe[0] <= word_of(bus_b.ram_addr);
    rb_pipe[1] <= rb_pipe[0];
    rb_pipe[2] <= rb_pipe[1];
  end
  assign bus_b.ram_rdata = rb_pipe[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  int a_hs = 0, a_first_hs = 0, a_last_hs = 0, a_gaps = 0;
  int b_hs = 0;
  bit a_gap_watch = 0;
  bit a_hold = 0, b_hold = 0;
  logic [31:0] a_hold_data, b_hold_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold = 0;
    end else begin
      if (a_hold) begin
        check("a_held_valid", bus_a.valid, 1);
        check("a_held_data", bus_a.data, a_hold_data);
      end
      if (bus_a.valid && bus_a.ready) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_word: got %0h required no word", bus_a.data);
        end else begin
          check("a_data", bus_a.data, exp_a.pop_front());
        end
        if (a_hs == 0) a_first_hs = cyc;
        a_hs++;
        a_last_hs = cyc;
      end
      if (a_gap_watch && a_busy && !bus_a.valid) a_gaps++;
      check("a_write_en", bus_a.ram_write_en, 0);
      a_hold      = bus_a.valid && !bus_a.ready;
      a_hold_data = bus_a.data;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_hold = 0;
    end else begin
      if (b_hold) begin
        check("b_held_valid", bus_b.valid, 1);
        check("b_held_data", bus_b.data, b_hold_data);
      end
      if (bus_b.valid && bus_b.ready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_word: got %0h required no word", bus_b.data);
        end else begin
          check("b_data", bus_b.data, exp_b.pop_front());
        end
        b_hs++;
      end
      check("b_fifo_bound", u_b.fifo_count <= 4, 1);
      b_hold      = bus_b.valid && !bus_b.ready;
      b_hold_data = bus_b.data;
    end
  end

  task automatic start_a(input int b, input int l, output int c);
    @(posedge clk); #1;
    a_start = 1; a_base = AW'(b); a_len = (AW+1)'(l);
    for (int k = 0; k < l; k++) exp_a.push_back(word_of(AW'((b + k) % DEPTH)));
    c = cyc;
    @(posedge clk); #1;
    a_start = 0;
  endtask

  task automatic start_b(input int b, input int l, output int c);
    @(posedge clk); #1;
    b_start = 1; b_base = AW'(b); b_len = (AW+1)'(l);
    for (int k = 0; k < l; k++) exp_b.push_back(word_of(AW'((b + k) % DEPTH)));
    c = cyc;
    @(posedge clk); #1;
    b_start = 0;
  endtask

  task automatic wait_done_a(output int d);
    int n = 0;
    d = -1;
    while (n < 1000) begin
      @(negedge clk);
      if (a_done) begin
        d = cyc;
        check("a_busy_at_done", a_busy, 0);
        break;
      end
      n++;
    end
    if (d < 0) begin
      checks++; errors++;
      $display("FAIL a_done_timeout: got no done, required done within 1000 cycles");
    end
    @(negedge clk);
    check("a_done_one_cycle", a_done, 0);
  endtask

  task automatic wait_done_b(input bit rnd, output int d);
    int n = 0;
    d = -1;
    while (n < 1000) begin
      @(posedge clk); #1;
      if (rnd) bus_b.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b_done) begin
        d = cyc;
        check("b_busy_at_done", b_busy, 0);
        break;
      end
      n++;
    end
    if (d < 0) begin
      checks++; errors++;
      $display("FAIL b_done_timeout: got no done, required done within 1000 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within 2 ms");
    $fatal(1);
  end

  initial begin
    int c, d;
    logic [AW-1:0] addr0;
    a_start = 0; a_base = '0; a_len = '0;
    b_start = 0; b_base = '0; b_len = '0;
    bus_a.ready = 1; bus_b.ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_valid", bus_a.valid, 0);
    check("rst_a_data", bus_a.data, 0);
    check("rst_a_addr", bus_a.ram_addr, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_valid", bus_b.valid, 0);
    check("rst_b_addr", bus_b.ram_addr, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // 1: base 0, len 8, ready held high
    a_hs = 0;
    start_a(0, 8, c);
    wait_done_a(d);
    check("t1_first_word_cycle", a_first_hs - c, 3);
    check("t1_last_word_cycle", a_last_hs - c, 10);
    check("t1_done_after_last", d - a_last_hs, 1);
    check("t1_word_count", a_hs, 8);
    check("t1_queue_empty", exp_a.size(), 0);

    // 3: wrap from 2046
    a_hs = 0;
    start_a(2046, 4, c);
    wait_done_a(d);
    check("t3_word_count", a_hs, 4);
    check("t3_queue_empty", exp_a.size(), 0);

    // 4: zero length
    a_hs = 0;
    addr0 = bus_a.ram_addr;
    start_a(77, 0, c);
    @(negedge clk);
    check("t4_done_pulse", a_done, 1);
    check("t4_busy_low", a_busy, 0);
    check("t4_addr_held", bus_a.ram_addr, addr0);
    @(negedge clk);
    check("t4_done_single", a_done, 0);
    check("t4_addr_still_held", bus_a.ram_addr, addr0);
    check("t4_no_words", a_hs, 0);

    // 5: 20-cycle stall with an ignored start while busy
    a_hs = 0;
    start_a(300, 12, c);
    repeat (4) @(posedge clk);
    #1 bus_a.ready = 0;
    repeat (5) @(posedge clk);
    #1 a_start = 1; a_base = '0; a_len = (AW+1)'(5);
    @(posedge clk);
    #1 a_start = 0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("t5_valid_held", bus_a.valid, 1);
    check("t5_busy_held", a_busy, 1);
    check("t5_issue_limit_addr", bus_a.ram_addr, AW'(300 + a_hs + 3));
    @(posedge clk); #1;
    a_gaps = 0; a_gap_watch = 1; bus_a.ready = 1;
    wait_done_a(d);
    a_gap_watch = 0;
    check("t5_no_gaps", a_gaps, 0);
    check("t5_word_count", a_hs, 12);
    check("t5_queue_empty", exp_a.size(), 0);

    // 2: LATENCY=3 instance, random ready
    b_hs = 0;
    start_b(64, 16, c);
    wait_done_b(1, d);
    bus_b.ready = 1;
    check("t2_word_count", b_hs, 16);
    check("t2_queue_empty", exp_b.size(), 0);

    // 6: reset with three reads in flight, then a fresh job
    b_hs = 0;
    bus_b.ready = 0;
    start_b(100, 10, c);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("t6_busy_rst", b_busy, 0);
    check("t6_done_rst", b_done, 0);
    check("t6_valid_rst", bus_b.valid, 0);
    check("t6_data_rst", bus_b.data, 0);
    check("t6_addr_rst", bus_b.ram_addr, 0);
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    bus_b.ready = 1;
    b_hs = 0;
    start_b(500, 2, c);
    wait_done_b(0, d);
    repeat (5) @(negedge clk);
    check("t6_word_count", b_hs, 2);
    check("t6_queue_empty", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
